// File: rtl/i8008_bus_responder_if.sv
// i8008_bus_responder_if: core-side, memory-side and I/O-side bus bundle.
// slave = the responder, master = the environment (core + memory + I/O).
interface i8008_bus_responder_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 14
);
    logic [2:0]            cpu_state;
    logic                  cpu_sync;
    logic [WIDTH-1:0]      cpu_dout;
    logic [WIDTH-1:0]      cpu_din;
    logic                  cpu_din_en;
    logic                  cpu_ready;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  mem_ack;
    logic                  io_req;
    logic                  io_we;
    logic [4:0]            io_port;
    logic [WIDTH-1:0]      io_wdata;
    logic [WIDTH-1:0]      io_rdata;
    logic                  io_ack;
    logic [2:0]            int_vector;
    logic                  int_ack;

    modport slave (
        input  cpu_state, cpu_sync, cpu_dout,
        input  mem_rdata, mem_ack, io_rdata, io_ack, int_vector,
        output cpu_din, cpu_din_en, cpu_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output io_req, io_we, io_port, io_wdata, int_ack
    );

    modport master (
        output cpu_state, cpu_sync, cpu_dout,
        output mem_rdata, mem_ack, io_rdata, io_ack, int_vector,
        input  cpu_din, cpu_din_en, cpu_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  io_req, io_we, io_port, io_wdata, int_ack
    );
endinterface

// File: rtl/i8008_bus_responder.sv
// i8008_bus_responder: decodes 8008 T1/T2/T3 and serves memory/I/O.
// Optional interrupt jam on T1I is enabled by defining I8008_INTR_JAM_EN.
module i8008_bus_responder #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 14
) (
    input logic                  clk,
    input logic                  reset,
    i8008_bus_responder_if.slave bus
);
    localparam int HI_W = ADDR_WIDTH - WIDTH;

    localparam logic [2:0] ST_T1  = 3'b010;
    localparam logic [2:0] ST_T1I = 3'b011;
    localparam logic [2:0] ST_T2  = 3'b001;
    localparam logic [2:0] ST_T3  = 3'b100;

    localparam logic [1:0] CT_PCI = 2'b00;
    localparam logic [1:0] CT_PCR = 2'b01;
    localparam logic [1:0] CT_PCC = 2'b10;
    localparam logic [1:0] CT_PCW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_RD,
        S_IO,
        S_DATA,
        S_WRD,
        S_WR
    } fsm_t;

    fsm_t                  state_q, state_d;
    logic [WIDTH-1:0]      lo_q, lo_d;
    logic [HI_W-1:0]       hi_q, hi_d;
    logic [1:0]            ctype_q, ctype_d;
    logic [WIDTH-1:0]      rbuf_q, rbuf_d;
    logic                  pend_q, pend_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic                  io_req_q, io_req_d;
    logic                  io_we_q, io_we_d;
    logic [4:0]            io_port_q, io_port_d;
    logic [WIDTH-1:0]      io_wdata_q, io_wdata_d;

    logic            t1_stb, t2_stb, t3_stb, busy;
    logic            go, int_ack_c, jam_hit;
    logic [1:0]      go_ct;
    logic [HI_W-1:0] go_hi;
    logic [WIDTH-1:0] jam_byte;

    assign t1_stb = bus.cpu_sync &&
                    (bus.cpu_state == ST_T1 || bus.cpu_state == ST_T1I);
    assign t2_stb = bus.cpu_sync && (bus.cpu_state == ST_T2);
    assign t3_stb = bus.cpu_sync && (bus.cpu_state == ST_T3);
    // A request from an aborted or posted access may still be in flight.
    assign busy   = mem_req_q | io_req_q;

`ifdef I8008_INTR_JAM_EN
    logic jam_q, jam_d;
    assign jam_hit  = jam_q && (bus.cpu_dout[WIDTH-1 -: 2] == CT_PCI);
    assign jam_byte = WIDTH'({2'b00, bus.int_vector, 3'b101});
`else
    logic unused_vec;
    assign unused_vec = ^bus.int_vector;
    assign jam_hit    = 1'b0;
    assign jam_byte   = '0;
`endif

    // Next-state, request issue/retire and read-data capture.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        ctype_d     = ctype_q;
        rbuf_d      = rbuf_q;
        pend_d      = pend_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        io_req_d    = io_req_q;
        io_we_d     = io_we_q;
        io_port_d   = io_port_q;
        io_wdata_d  = io_wdata_q;
        go          = 1'b0;
        go_ct       = ctype_q;
        go_hi       = hi_q;
        int_ack_c   = 1'b0;
`ifdef I8008_INTR_JAM_EN
        jam_d       = jam_q;
`endif

        if (mem_req_q && bus.mem_ack) mem_req_d = 1'b0;
        if (io_req_q && bus.io_ack) io_req_d = 1'b0;

        unique case (state_q)
            S_ADDR: begin
                if (t2_stb) begin
                    hi_d    = bus.cpu_dout[HI_W-1:0];
                    ctype_d = bus.cpu_dout[WIDTH-1 -: 2];
                    go_hi   = bus.cpu_dout[HI_W-1:0];
                    go_ct   = bus.cpu_dout[WIDTH-1 -: 2];
                    if (jam_hit) begin
                        rbuf_d    = jam_byte;
                        int_ack_c = 1'b1;
                        state_d   = S_DATA;
                    end else if (busy) begin
                        pend_d = 1'b1;
                    end else begin
                        go = 1'b1;
                    end
                end else if (pend_q && !busy) begin
                    pend_d = 1'b0;
                    go     = 1'b1;
                end
            end
            S_RD: begin
                if (mem_req_q && bus.mem_ack) begin
                    rbuf_d  = bus.mem_rdata;
                    state_d = S_DATA;
                end
            end
            S_IO: begin
                if (io_req_q && bus.io_ack) begin
                    if (io_we_q) begin
                        state_d = S_IDLE;
                    end else begin
                        rbuf_d  = bus.io_rdata;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (t3_stb) state_d = S_IDLE;
            end
            S_WRD: begin
                if (t3_stb) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {hi_q, lo_q};
                    mem_wdata_d = bus.cpu_dout;
                    state_d     = S_WR;
                end
            end
            S_WR: begin
                if (mem_req_q && bus.mem_ack) state_d = S_IDLE;
            end
            default: ;
        endcase

        if (go) begin
            unique case (go_ct)
                CT_PCI, CT_PCR: begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {go_hi, lo_q};
                    state_d    = S_RD;
                end
                CT_PCC: begin
                    io_req_d   = 1'b1;
                    io_we_d    = |go_hi[HI_W-1 -: 2];
                    io_port_d  = go_hi[HI_W-1 -: 5];
                    io_wdata_d = lo_q;
                    state_d    = S_IO;
                end
                CT_PCW: begin
                    state_d = S_WRD;
                end
            endcase
        end

        if (t1_stb) begin
            lo_d    = bus.cpu_dout;
            pend_d  = 1'b0;
            state_d = S_ADDR;
`ifdef I8008_INTR_JAM_EN
            jam_d   = (bus.cpu_state == ST_T1I);
`endif
        end
    end

    // State and request registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lo_q        <= '0;
            hi_q        <= '0;
            ctype_q     <= '0;
            rbuf_q      <= '0;
            pend_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            io_req_q    <= 1'b0;
            io_we_q     <= 1'b0;
            io_port_q   <= '0;
            io_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            ctype_q     <= ctype_d;
            rbuf_q      <= rbuf_d;
            pend_q      <= pend_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            io_req_q    <= io_req_d;
            io_we_q     <= io_we_d;
            io_port_q   <= io_port_d;
            io_wdata_q  <= io_wdata_d;
        end
    end

`ifdef I8008_INTR_JAM_EN
    // Interrupt-acknowledge marker set by the T1I strobe.
    always_ff @(posedge clk) begin
        if (reset) jam_q <= 1'b0;
        else       jam_q <= jam_d;
    end
`endif

    assign bus.cpu_din    = (state_q == S_DATA) ? rbuf_q : '0;
    assign bus.cpu_din_en = (state_q == S_DATA);
    assign bus.cpu_ready  = !((state_q == S_RD) ||
                              (state_q == S_IO && !io_we_q) ||
                              pend_q);
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.io_req     = io_req_q;
    assign bus.io_we      = io_we_q;
    assign bus.io_port    = io_port_q;
    assign bus.io_wdata   = io_wdata_q;
    assign bus.int_ack    = int_ack_c;
endmodule

// File: tb/tb_i8008_bus_responder.sv
// tb_i8008_bus_responder: core emulation, memory/I/O responders,
// transaction-level model and per-cycle compare process.
module tb_i8008_bus_responder;
    localparam logic [2:0] ST_WAIT = 3'b000;
    localparam logic [2:0] ST_T1   = 3'b010;
    localparam logic [2:0] ST_T1I  = 3'b011;
    localparam logic [2:0] ST_T2   = 3'b001;
    localparam logic [2:0] ST_T3   = 3'b100;
    localparam logic [2:0] ST_T4   = 3'b111;
    localparam logic [2:0] ST_T5   = 3'b101;

    typedef struct {
        logic [13:0] addr;
        logic        we;
        logic [7:0]  data;
    } mreq_t;

    typedef struct {
        logic [4:0] port;
        logic       we;
        logic [7:0] data;
    } ioreq_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    i8008_bus_responder_if #(.WIDTH(8), .ADDR_WIDTH(14)) bus ();

    i8008_bus_responder #(.WIDTH(8), .ADDR_WIDTH(14)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    int rd_delay = 3, wr_delay = 2, io_delay = 2;
    int mrises = 0, int_pulses = 0, exp_int = 0;
    logic in_t3_rd = 1'b0;
    logic [7:0] ram [0:16383];
    logic [7:0] model_mem [0:16383];
    mreq_t  exp_m [$];
    ioreq_t exp_io [$];
    logic [7:0] exp_din [$];
    logic [13:0] last_maddr;
    logic        last_mwe;
    logic [7:0]  last_mwdata;
    logic [4:0]  last_port;
    logic        last_iowe;
    logic [7:0]  last_iowdata;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [7:0] io_val(input logic [4:0] p);
        return (p == 5'd3) ? 8'hA5 : ({3'b000, p} ^ 8'h5C);
    endfunction

    // Transaction model: what a bus cycle must produce.
    task automatic model_txn(input logic [2:0] t1s, input logic [7:0] lo,
                             input logic [7:0] hi, input logic [7:0] wd);
        logic [1:0]  ct;
        logic [13:0] a;
        logic [4:0]  p;
        ct = hi[7:6];
        a  = {hi[5:0], lo};
        p  = hi[5:1];
`ifdef I8008_INTR_JAM_EN
        if (t1s == ST_T1I && ct == 2'b00) begin
            exp_din.push_back({2'b00, bus.int_vector, 3'b101});
            exp_int++;
            return;
        end
`endif
        if (ct == 2'b11) begin
            exp_m.push_back('{a, 1'b1, wd});
            model_mem[a] = wd;
        end else if (ct == 2'b10) begin
            if (p >= 5'd8) begin
                exp_io.push_back('{p, 1'b1, lo});
            end else begin
                exp_io.push_back('{p, 1'b0, 8'h00});
                exp_din.push_back(io_val(p));
            end
        end else begin
            exp_m.push_back('{a, 1'b0, 8'h00});
            exp_din.push_back(model_mem[a]);
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic sy,
                         input logic [7:0] d);
        bus.cpu_state = s;
        bus.cpu_sync  = sy;
        bus.cpu_dout  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_cycle(input logic [2:0] t1s, input logic [7:0] lo,
                             input logic [7:0] hi, input logic [7:0] wd,
                             output logic [7:0] rd, output int waits);
        logic rdc;
        rdc = (hi[7:6] != 2'b11) &&
              !(hi[7:6] == 2'b10 && hi[5:4] != 2'b00);
        model_txn(t1s, lo, hi, wd);
        drive(t1s, 1'b1, lo);
        drive(ST_T2, 1'b1, hi);
        waits = 0;
        while (!bus.cpu_ready && waits < 100) begin
            drive(ST_WAIT, 1'b1, 8'h00);
            waits++;
        end
        if (waits >= 100) fail_now("ready_timeout");
        bus.cpu_state = ST_T3;
        bus.cpu_sync  = 1'b1;
        bus.cpu_dout  = wd;
        in_t3_rd      = rdc;
        @(negedge clk);
        rd = bus.cpu_din;
        @(posedge clk);
        #1;
        in_t3_rd = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        drive(ST_T4, 1'b1, 8'h00);
        while ((bus.mem_req || bus.io_req) && n < 100) begin
            drive(ST_T5, 1'b1, 8'h00);
            n++;
        end
        if (n >= 100) fail_now("settle_timeout");
        drive(ST_WAIT, 1'b0, 8'h00);
    endtask

    // Memory responder.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                cnt++;
                if (cnt >= (bus.mem_we ? wr_delay : rd_delay)) begin
                    cnt = 0;
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) ram[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = ram[bus.mem_addr];
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // I/O responder.
    initial begin
        int cnt;
        cnt = 0;
        bus.io_ack   = 1'b0;
        bus.io_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            bus.io_ack = 1'b0;
            if (bus.io_req) begin
                cnt++;
                if (cnt >= io_delay) begin
                    cnt = 0;
                    bus.io_ack = 1'b1;
                    if (!bus.io_we) bus.io_rdata = io_val(bus.io_port);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Compare process: requests, holding, read data and int_ack.
    initial begin
        logic pm, pio, pint;
        mreq_t  e;
        ioreq_t f;
        pm = 1'b0;
        pio = 1'b0;
        pint = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req && !pm) begin
                mrises++;
                last_maddr  = bus.mem_addr;
                last_mwe    = bus.mem_we;
                last_mwdata = bus.mem_wdata;
                if (exp_m.size() == 0) begin
                    fail_now("mem_req_unexpected");
                end else begin
                    e = exp_m.pop_front();
                    chk("mem_addr", bus.mem_addr, e.addr);
                    chk("mem_we", bus.mem_we, e.we);
                    if (e.we) chk("mem_wdata", bus.mem_wdata, e.data);
                end
            end else if (bus.mem_req) begin
                chk("mem_hold", {bus.mem_addr, bus.mem_we, bus.mem_wdata},
                    {last_maddr, last_mwe, last_mwdata});
            end
            if (bus.io_req && !pio) begin
                last_port    = bus.io_port;
                last_iowe    = bus.io_we;
                last_iowdata = bus.io_wdata;
                if (exp_io.size() == 0) begin
                    fail_now("io_req_unexpected");
                end else begin
                    f = exp_io.pop_front();
                    chk("io_port", bus.io_port, f.port);
                    chk("io_we", bus.io_we, f.we);
                    if (f.we) chk("io_wdata", bus.io_wdata, f.data);
                end
            end else if (bus.io_req) begin
                chk("io_hold", {bus.io_port, bus.io_we, bus.io_wdata},
                    {last_port, last_iowe, last_iowdata});
            end
            if (in_t3_rd) begin
                chk("din_en", bus.cpu_din_en, 1'b1);
                if (exp_din.size() == 0) fail_now("din_unexpected");
                else chk("cpu_din", bus.cpu_din, exp_din.pop_front());
            end
            if (bus.int_ack) begin
                int_pulses++;
                chk("int_ack_single", pint, 1'b0);
            end
            pm   = bus.mem_req;
            pio  = bus.io_req;
            pint = bus.int_ack;
        end
    end

    initial begin
        logic [7:0] rd;
        int w, r0, i0;
        reset          = 1'b1;
        bus.cpu_state  = ST_WAIT;
        bus.cpu_sync   = 1'b0;
        bus.cpu_dout   = 8'h00;
        bus.int_vector = 3'd5;
        for (int i = 0; i < 16384; i++) begin
            ram[i]       = 8'((i * 37 + 11) & 8'hFF);
            model_mem[i] = 8'((i * 37 + 11) & 8'hFF);
        end
        ram[14'h1234]       = 8'hC0;
        model_mem[14'h1234] = 8'hC0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.cpu_ready, 1'b1);
        chk("rst_din", {bus.cpu_din_en, bus.cpu_din}, 9'h000);
        chk("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr,
                        bus.mem_wdata}, 24'h0);
        chk("rst_io", {bus.io_req, bus.io_we, bus.io_port, bus.io_wdata},
            15'h0);
        chk("rst_int", bus.int_ack, 1'b0);
        reset = 1'b0;
        drive(ST_WAIT, 1'b0, 8'h00);

        rd_delay = 3;
        bus_cycle(ST_T1, 8'h34, 8'h12, 8'h00, rd, w);
        chk("fetch_data", rd, 8'hC0);
        chk("fetch_waits", w, 3);
        chk("fetch_addr", last_maddr, 14'h1234);
        settle();

        r0 = mrises;
        wr_delay = 2;
        bus_cycle(ST_T1, 8'hFF, 8'hFF, 8'h5A, rd, w);
        chk("wr_waits", w, 0);
        settle();
        chk("wr_addr", last_maddr, 14'h3FFF);
        chk("wr_we_data", {last_mwe, last_mwdata}, 9'h15A);
        chk("wr_one_req", mrises - r0, 1);

        bus_cycle(ST_T1, 8'hFF, 8'h7F, 8'h00, rd, w);
        chk("rdback_data", rd, 8'h5A);
        settle();

        wr_delay = 6;
        rd_delay = 3;
        bus_cycle(ST_T1, 8'h55, 8'hC1, 8'h3C, rd, w);
        chk("b2b_wr_waits", w, 0);
        bus_cycle(ST_T1, 8'h55, 8'h41, 8'h00, rd, w);
        chk("b2b_rd_waits", w, 8);
        chk("b2b_rd_data", rd, 8'h3C);
        settle();

        io_delay = 2;
        bus_cycle(ST_T1, 8'h77, 8'h90, 8'h00, rd, w);
        chk("ioout_waits", w, 0);
        settle();
        chk("ioout_port", last_port, 5'd8);
        chk("ioout_we_data", {last_iowe, last_iowdata}, 9'h177);

        bus_cycle(ST_T1, 8'h11, 8'h86, 8'h00, rd, w);
        chk("ioin_data", rd, 8'hA5);
        chk("ioin_waits", w, 2);
        chk("ioin_port", last_port, 5'd3);
        settle();

        r0 = mrises;
        i0 = int_pulses;
        rd_delay = 3;
        bus.int_vector = 3'd5;
        bus_cycle(ST_T1I, 8'h00, 8'h00, 8'h00, rd, w);
`ifdef I8008_INTR_JAM_EN
        chk("jam_data", rd, 8'h2D);
        chk("jam_waits", w, 0);
        chk("jam_no_req", mrises - r0, 0);
        chk("jam_int_ack", int_pulses - i0, 1);
`else
        chk("t1i_fetch_data", rd, 8'h0B);
        chk("t1i_fetch_waits", w, 3);
        chk("t1i_one_req", mrises - r0, 1);
        chk("t1i_no_int", int_pulses - i0, 0);
`endif
        settle();

        rd_delay = 50;
        exp_m.push_back('{14'h0510, 1'b0, 8'h00});
        drive(ST_T1, 1'b1, 8'h10);
        drive(ST_T2, 1'b1, 8'h45);
        chk("rstmid_req_up", {bus.mem_req, bus.cpu_ready}, 2'b10);
        reset = 1'b1;
        drive(ST_WAIT, 1'b0, 8'h00);
        chk("rstmid_ready", bus.cpu_ready, 1'b1);
        chk("rstmid_mem", {bus.mem_req, bus.mem_we, bus.mem_addr,
                           bus.mem_wdata}, 24'h0);
        chk("rstmid_din", {bus.cpu_din_en, bus.cpu_din}, 9'h000);
        chk("rstmid_io", {bus.io_req, bus.int_ack}, 2'b00);
        reset = 1'b0;
        drive(ST_WAIT, 1'b0, 8'h00);

        rd_delay = 1;
        bus_cycle(ST_T1, 8'h34, 8'h12, 8'h00, rd, w);
        chk("post_rst_data", rd, 8'hC0);
        chk("post_rst_waits", w, 1);
        settle();

        chk("exp_m_empty", exp_m.size(), 0);
        chk("exp_io_empty", exp_io.size(), 0);
        chk("exp_din_empty", exp_din.size(), 0);
        chk("int_total", int_pulses, exp_int);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i8008_bus_responder.md
# i8008_bus_responder

Memory/I/O-side responder for the 8008 core's multiplexed bus. Watches the core's `state`, `Sync` and `D_out`, then reassembles the 14-bit address and cycle type from T1/T2. It runs a req/ack transaction on a memory port or an I/O port and returns read data on the core's `D_in` during T3, holding `Ready` low until that data exists. It sits between `8008_core` and system memory/peripherals and is the only driver of the core's `D_in` and `Ready`.

## Interface
- `WIDTH`, 8: data bus width.
- `ADDR_WIDTH`, 14: memory address width, low 8 bits from T1 and high 6 bits from T2.
- `clk` input 1: single system clock; all logic on posedge.
- `reset` input 1: synchronous, active-high.
- `cpu_state` input 3 (`state_t`): core state. T1=010, T1I=011, T2=001, WAIT=000, T3=100, STOPPED=110, T4=111, T5=101.
- `cpu_sync` input 1: core `Sync`; inputs are qualified only on cycles with `cpu_sync`=1 ("strobe").
- `cpu_dout` input WIDTH: core `D_out`.
- `cpu_din` output WIDTH: core `D_in`.
- `cpu_din_en` output 1: high while `cpu_din` is valid (T3 of read/fetch/input).
- `cpu_ready` output 1: core `Ready`.
- `mem_req` output 1; `mem_we` output 1; `mem_addr` output ADDR_WIDTH; `mem_wdata` output WIDTH.
- `mem_rdata` input WIDTH; `mem_ack` input 1.
- `io_req` output 1; `io_we` output 1; `io_port` output 5; `io_wdata` output WIDTH.
- `io_rdata` input WIDTH; `io_ack` input 1.
- `int_vector` input 3: RST target for interrupt jam (only used when jam is compiled in).
- `int_ack` output 1: one-cycle pulse when the jam is returned (only when jam is compiled in).

## Operation
- Cycle type is taken from D7:D6 at T2:
  - 00 PCI: fetch, memory read.
  - 01 PCR: memory read.
  - 10 PCC: I/O.
  - 11 PCW: memory write.
- T1/T1I strobe: latch `cpu_dout` into `lo`.
- T2 strobe: latch D5:D0 into `hi` and D7:D6 into `ctype`.
- FSM states:
  - IDLE: T1/T1I strobe → ADDR.
  - ADDR: T2 strobe → one of:
    - RD if ctype ∈ {PCI, PCR}.
    - IO if PCC.
    - WRD if PCW.
  - RD:
    - `mem_req`=1, `mem_we`=0, `mem_addr`={hi,lo}.
    - On `mem_ack`: capture `mem_rdata` into `rbuf`, drop `mem_req` the next cycle, go to DATA.
  - IO:
    - `io_port`=hi[5:1]; `io_we`=(hi[5:4]≠00), i.e. ports 8–31 are output.
    - Output: `io_wdata`=lo (the accumulator at T1), `io_req`=1 until `io_ack`, then IDLE.
    - Input: `io_req`=1 until `io_ack`; capture `io_rdata` into `rbuf`, go to DATA.
  - DATA: drive `cpu_din`=`rbuf`, `cpu_din_en`=1 until the T3 strobe passes, then IDLE.
  - WRD: capture `cpu_dout` at the T3 strobe → WR.
  - WR (posted write):
    - `mem_req`=1, `mem_we`=1, `mem_addr`={hi,lo}, `mem_wdata`=captured byte, held until `mem_ack`.
    - Then IDLE.
    - The core is not stalled by a posted write.
- Outputs `mem_*`/`io_*` are stable for the whole time their `*_req` is high. Each request is held until its ack; an ack with no request pending is ignored.
- `cpu_ready`=0 in these cases:
  - RD or input-IO, until the data is captured.
  - A new T2 strobe arrives while WR is still pending: the new access is queued (state retained), Ready stays low until WR acks, then the new access starts.
- `cpu_ready`=1 otherwise.
- STOPPED, T4 and T5 strobes are ignored. A T1 strobe in any state other than IDLE/WR restarts at ADDR; any request outstanding at that point is held until its ack, and its data is discarded.

## Timing
- Reset values:
  - `cpu_ready`=1.
  - All other outputs 0, `rbuf`=0, FSM=IDLE.
  - Reset mid-transaction drops `*_req` on the next cycle with no completion.
- `mem_req`/`io_req` rise in the cycle after the T2 strobe (or after the T3 strobe for writes).
- Read latency: `mem_ack` in cycle N gives `cpu_ready`=1 and `cpu_din_en`=1 in cycle N+1.
- `cpu_ready` falls in the cycle after the T2 strobe, i.e. before the core samples Ready for its T3 entry.
- `int_ack` is a single-cycle pulse.

## Configuration
- `I8008_INTR_JAM_EN`, defined:
  - A T1I strobe marks the cycle as an interrupt acknowledge.
  - At T2 (PCI) no memory request is issued.
  - `rbuf`={2'b00, `int_vector`, 3'b101} (RST instruction), direct to DATA with zero wait.
  - `int_ack` pulses for one cycle at that T2 strobe.
- `I8008_INTR_JAM_EN`, undefined:
  - T1I is treated as T1, a normal memory fetch.
  - `int_ack` is tied 0 and `int_vector` is unused.

## Test plan
- Fetch: T1 `cpu_dout`=0x34, T2 0x12 (PCI), `mem_ack` 3 cycles later with `mem_rdata`=0xC0 → `mem_addr`=0x1234, `cpu_ready` low 3 cycles, then `cpu_din`=0xC0 at T3.
- Write: T1 0xFF, T2 0xFF (PCW, addr 0x3FFF), T3 data 0x5A → one `mem_req` with `mem_we`=1 and `mem_wdata`=0x5A; `cpu_ready` stays 1.
- Back-to-back: posted write unacked for 6 cycles, then a read T2 → `cpu_ready` stays low until the write ack; the read request follows; no write lost.
- I/O: T1 0x77, T2 0x90 (PCC, port 8) → `io_we`=1, `io_port`=8, `io_wdata`=0x77. A second run with T2 0x86 (port 3) and `io_rdata`=0xA5 → `cpu_din`=0xA5.
- Jam (with `I8008_INTR_JAM_EN`): T1I, `int_vector`=5, T2 PCI → `cpu_din`=0x2D, no `mem_req`, `int_ack` single pulse. Without the macro → normal fetch.
- Reset asserted during RD with `mem_req` high → the next cycle shows all outputs at reset values and `cpu_ready`=1.
